l2_cache_tag_array: RTL and testbench
=====================================

// Module: l2_cache_tag_array
// PURPOSE
//  Parametrised L2 tag-check stage: N-way set-associative tag, valid, dirty and tree-PLRU state.
//  Sits between the L2 arbiter and the L2 read/dir stage. Reads are issued here with 1-cycle latency.
//  The next stage returns tag/dirty/MRU updates.
//  Adds over the 4-way stage:
//  - any power-of-2 way count;
//  - a post-reset invalidate sweep with arb_ready back-pressure;
//  - same-set LRU forwarding;
//  - optional same-cycle write-to-read bypass.
// PARAMETERS
//  NUM_WAYS   4    ways per set; power of 2, >= 2
//  NUM_SETS   256  sets; power of 2
//  TAG_WIDTH  18   tag bits per line
//  (derived) WAY_W = $clog2(NUM_WAYS), SET_W = $clog2(NUM_SETS)
// PORTS
//  clk             in   1                   clock
//  reset           in   1                   synchronous, active-high
//  arb_valid       in   1                   request present
//  arb_set         in   SET_W               set index of request
//  arb_is_fill     in   1                   request is an L2 fill restart
//  arb_ready       out  1                   0 during init sweep; requests must not be issued
//  tag_valid       out  1                   stage output valid (arb_valid delayed 1)
//  tag_set         out  SET_W               registered arb_set
//  tag_is_fill     out  1                   registered arb_is_fill
//  tag_fill_way    out  WAY_W               PLRU victim for tag_set
//  tag_l2_tag      out  NUM_WAYS*TAG_WIDTH  per-way tags, way i at [i*TAG_WIDTH +: TAG_WIDTH]
//  tag_l2_valid    out  NUM_WAYS            per-way valid bits, gated by tag_valid
//  tag_l2_dirty    out  NUM_WAYS            per-way dirty bits, gated by tag_valid
//  upd_tag_en      in   1                   write tag and valid
//  upd_tag_set     in   SET_W               set to write
//  upd_tag_way     in   WAY_W               way to write
//  upd_tag_tag     in   TAG_WIDTH           new tag
//  upd_tag_valid   in   1                   new valid bit
//  upd_dirty_en    in   NUM_WAYS            per-way dirty write enable
//  upd_dirty_set   in   SET_W               set to write
//  upd_dirty_val   in   1                   new dirty value
//  hit_way         in   WAY_W               hit way from next stage, used for MRU update
//  init_done       out  1                   sticky 1 once sweep completes
// BEHAVIOUR
//  Reset values:
//  - All outputs are 0: tag_valid, tag_is_fill, tag_fill_way, tag_set, arb_ready, init_done.
//  - tag_l2_valid and tag_l2_dirty are 0. tag_l2_tag is don't-care while tag_valid=0.
//  FSM INIT -> RUN:
//  - INIT: sweep counter from 0, one set per cycle. Each cycle clears valid, dirty and PLRU bits of all ways.
//  - At set NUM_SETS-1, go to RUN next cycle: arb_ready=1, init_done=1. The sweep takes exactly NUM_SETS cycles.
//  - Reset asserted mid-sweep restarts the counter at 0. There is no way back to INIT except reset.
//  - arb_valid while arb_ready=0 is ignored (no read, tag_valid stays 0); an assertion fires.
//  Latency: arb_valid at cycle N gives tag_* valid at N+1. There is no stall input; the stage always advances.
//  PLRU:
//  - NUM_WAYS-1 bits per set.
//  - Victim: walk from the root, bit 0 = go left.
//  - Updating way W sets the bits on W's path to point away from W.
//  - MRU update happens in the cycle tag_valid=1: way = tag_is_fill ? tag_fill_way : hit_way.
//  LRU forwarding (always on):
//  - Condition: arb_set == tag_set with both valid.
//  - The read uses the post-update PLRU bits, so back-to-back same-set fills choose different ways.
//  Tag and dirty writes take effect at the clock edge. Reads issued in the same cycle see the old value unless bypass is on.
//  Tag writes and dirty writes to the same set/way in one cycle are legal and independent.
//  The sweep has priority over upd_* (upd_* while INIT is ignored; an assertion fires).
// CONFIGURATION
//  L2_CACHE_TAG_BYPASS_EN defined:
//  - Applies when a read and a write to the same set and way happen in the same cycle.
//  - Returned tag, valid and dirty equal the written values; forwarding is registered alongside the SRAM read.
//  Not defined:
//  - The old value is returned.
//  - An assertion flags the collision as an arbiter protocol violation.
// STRUCTURE
//  defines.sv / shared package:
//  - typedefs l2_set_idx_t, l2_way_idx_t, l2_tag_t;
//  - L2_NUM_WAYS, L2_NUM_SETS and L2_TAG_WIDTH defaults.
//  Per way: sram_1r1w for tags, cache_valid_array for valid, 1-bit sram_1r1w for dirty. All are cleared via the sweep port mux.
//  Sub-module l2_plru_tree (combinational, parametrised NUM_WAYS):
//  - inputs: PLRU bits, update way;
//  - outputs: victim way, new bits.
//  - Instantiated once; PLRU storage lives in a flop array in this module.
// TESTING
//  1. Reset, then idle: arb_ready=0 for exactly 256 cycles, init_done=1 at cycle 256, all tag_l2_valid=0 on set-0 read.
//  2. NUM_WAYS=4: 4 fills to set 5 back-to-back -> tag_fill_way sequence 0,2,1,3 (tree order); 5th fill -> way 0.
//  3. upd_tag (set 9, way 2, tag 0x1234, valid=1), read set 9 next cycle -> tag_l2_valid=4'b0100, way 2 tag=0x1234.
//  4. Same-cycle upd_tag and read of set 9 way 1 -> bypass on: new tag and valid=1; bypass off: old value and an assertion.
//  5. upd_dirty_en=4'b1000 on set 3 with val=1, then val=0, reading after each -> dirty 4'b1000 then 4'b0000.
//  6. Reset asserted at sweep set 100 after set 7 was written -> sweep restarts at 0, takes 256 more cycles, set 7 reads invalid.

Source files
------------

// File: rtl/l2_cache_tag_array_pkg.sv
// Shared types and default geometry for the L2 tag-check stage.
// Optional bypass feature: L2_CACHE_TAG_BYPASS_EN.
package l2_cache_tag_array_pkg;

    localparam int L2_NUM_WAYS  = 4;
    localparam int L2_NUM_SETS  = 256;
    localparam int L2_TAG_WIDTH = 18;

    typedef logic [$clog2(L2_NUM_SETS)-1:0] l2_set_idx_t;
    typedef logic [$clog2(L2_NUM_WAYS)-1:0] l2_way_idx_t;
    typedef logic [L2_TAG_WIDTH-1:0]        l2_tag_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } l2_tag_state_t;

endpackage

// File: rtl/l2_cache_tag_array_plru.sv
// Tree pseudo-LRU logic: victim walk and MRU path update.
// Node n has children 2n+1 (left) and 2n+2 (right); bit 0 means go left.
module l2_plru_tree
    import l2_cache_tag_array_pkg::*;
#(
    parameter int NUM_WAYS = L2_NUM_WAYS
) (
    input  logic [NUM_WAYS-2:0]         rd_bits,
    output logic [$clog2(NUM_WAYS)-1:0] victim,
    input  logic [NUM_WAYS-2:0]         upd_bits,
    input  logic [$clog2(NUM_WAYS)-1:0] upd_way,
    output logic [NUM_WAYS-2:0]         new_bits
);

    localparam int WAY_W = $clog2(NUM_WAYS);

    always_comb begin
        int   node;
        logic b;
        node   = 0;
        b      = 1'b0;
        victim = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == node) b = rd_bits[n];
            end
            victim[WAY_W-1-l] = b;
            node = 2 * node + 1 + int'(b);
        end
    end

    // Each node on the touched way's path is flipped to point away from it.
    always_comb begin
        int   node;
        logic d;
        node     = 0;
        d        = 1'b0;
        new_bits = upd_bits;
        for (int l = 0; l < WAY_W; l++) begin
            d = upd_way[WAY_W-1-l];
            for (int n = 0; n < NUM_WAYS - 1; n++) begin
                if (n == node) new_bits[n] = ~d;
            end
            node = 2 * node + 1 + int'(d);
        end
    end

endmodule

// File: rtl/l2_cache_tag_array.sv
// L2 tag-check stage: set-associative tag/valid/dirty/PLRU with init sweep.
// Define L2_CACHE_TAG_BYPASS_EN for same-cycle write-to-read bypass.
module l2_cache_tag_array
    import l2_cache_tag_array_pkg::*;
#(
    parameter int NUM_WAYS  = L2_NUM_WAYS,
    parameter int NUM_SETS  = L2_NUM_SETS,
    parameter int TAG_WIDTH = L2_TAG_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arb_valid,
    input  logic [$clog2(NUM_SETS)-1:0]   arb_set,
    input  logic                          arb_is_fill,
    output logic                          arb_ready,
    output logic                          tag_valid,
    output logic [$clog2(NUM_SETS)-1:0]   tag_set,
    output logic                          tag_is_fill,
    output logic [$clog2(NUM_WAYS)-1:0]   tag_fill_way,
    output logic [NUM_WAYS*TAG_WIDTH-1:0] tag_l2_tag,
    output logic [NUM_WAYS-1:0]           tag_l2_valid,
    output logic [NUM_WAYS-1:0]           tag_l2_dirty,
    input  logic                          upd_tag_en,
    input  logic [$clog2(NUM_SETS)-1:0]   upd_tag_set,
    input  logic [$clog2(NUM_WAYS)-1:0]   upd_tag_way,
    input  logic [TAG_WIDTH-1:0]          upd_tag_tag,
    input  logic                          upd_tag_valid,
    input  logic [NUM_WAYS-1:0]           upd_dirty_en,
    input  logic [$clog2(NUM_SETS)-1:0]   upd_dirty_set,
    input  logic                          upd_dirty_val,
    input  logic [$clog2(NUM_WAYS)-1:0]   hit_way,
    output logic                          init_done
);

    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    l2_tag_state_t    state_q, state_d;
    logic [SET_W-1:0] sweep_q, sweep_d;

    logic [TAG_WIDTH-1:0] tag_mem   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_mem [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_mem [NUM_SETS];
    logic [NUM_WAYS-2:0]  plru_mem  [NUM_SETS];

    logic                 sweeping;
    logic                 rd_fire;
    logic                 fwd;
    logic [NUM_WAYS-2:0]  rd_bits;
    logic [NUM_WAYS-2:0]  new_bits;
    logic [WAY_W-1:0]     victim;
    logic [WAY_W-1:0]     mru_way;
    logic [TAG_WIDTH-1:0] nx_tag [NUM_WAYS];
    logic [TAG_WIDTH-1:0] rd_tag [NUM_WAYS];
    logic [NUM_WAYS-1:0]  nx_valid, nx_dirty;
    logic [NUM_WAYS-1:0]  rd_valid, rd_dirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            ST_INIT: begin
                if (sweep_q == LAST_SET) state_d = ST_RUN;
                else                     sweep_d = sweep_q + SET_W'(1);
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign sweeping  = (state_q == ST_INIT);
    assign arb_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign rd_fire   = arb_valid & arb_ready;

    // Same-set back-to-back reads see the PLRU bits being written this cycle.
    assign fwd     = tag_valid && (arb_set == tag_set);
    assign mru_way = tag_is_fill ? tag_fill_way : hit_way;
    assign rd_bits = fwd ? new_bits : plru_mem[arb_set];

    l2_plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .rd_bits  (rd_bits),
        .victim   (victim),
        .upd_bits (plru_mem[tag_set]),
        .upd_way  (mru_way),
        .new_bits (new_bits)
    );

    always_comb begin
        nx_valid = valid_mem[arb_set];
        nx_dirty = dirty_mem[arb_set];
        for (int w = 0; w < NUM_WAYS; w++) nx_tag[w] = tag_mem[arb_set][w];
`ifdef L2_CACHE_TAG_BYPASS_EN
        if (upd_tag_en && upd_tag_set == arb_set) begin
            nx_tag[upd_tag_way]   = upd_tag_tag;
            nx_valid[upd_tag_way] = upd_tag_valid;
        end
        if (upd_dirty_set == arb_set) begin
            nx_dirty = (nx_dirty & ~upd_dirty_en)
                     | (upd_dirty_en & {NUM_WAYS{upd_dirty_val}});
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid    <= 1'b0;
            tag_set      <= '0;
            tag_is_fill  <= 1'b0;
            tag_fill_way <= '0;
            rd_valid     <= '0;
            rd_dirty     <= '0;
        end else begin
            tag_valid   <= rd_fire;
            tag_is_fill <= rd_fire & arb_is_fill;
            if (rd_fire) begin
                tag_set      <= arb_set;
                tag_fill_way <= victim;
                rd_valid     <= nx_valid;
                rd_dirty     <= nx_dirty;
                rd_tag       <= nx_tag;
            end
        end
    end

    // Sweep wins over every update port while initialising.
    always_ff @(posedge clk) begin
        if (sweeping) begin
            valid_mem[sweep_q] <= '0;
            dirty_mem[sweep_q] <= '0;
            plru_mem[sweep_q]  <= '0;
        end else begin
            if (upd_tag_en) begin
                tag_mem[upd_tag_set][upd_tag_way]   <= upd_tag_tag;
                valid_mem[upd_tag_set][upd_tag_way] <= upd_tag_valid;
            end
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (upd_dirty_en[w]) dirty_mem[upd_dirty_set][w] <= upd_dirty_val;
            end
            if (tag_valid) plru_mem[tag_set] <= new_bits;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_tag_out
        assign tag_l2_tag[w*TAG_WIDTH +: TAG_WIDTH] = rd_tag[w];
    end

    assign tag_l2_valid = rd_valid & {NUM_WAYS{tag_valid}};
    assign tag_l2_dirty = rd_dirty & {NUM_WAYS{tag_valid}};

    a_no_req_in_init: assert property (@(posedge clk) disable iff (reset)
        arb_valid |-> arb_ready)
        else $error("arb_valid asserted during init sweep");

    a_no_upd_in_init: assert property (@(posedge clk) disable iff (reset)
        sweeping |-> !(upd_tag_en || (|upd_dirty_en)))
        else $error("update issued during init sweep");

`ifndef L2_CACHE_TAG_BYPASS_EN
    a_no_rw_collision: assert property (@(posedge clk) disable iff (reset)
        rd_fire |-> !((upd_tag_en && upd_tag_set == arb_set) ||
                      ((|upd_dirty_en) && upd_dirty_set == arb_set)))
        else $error("arbiter issued read and write to the same set");
`endif

endmodule

// File: tb/tb_l2_cache_tag_array.sv
// Randomised bench for l2_cache_tag_array against an array/tree reference model.
// Bypass expectations follow L2_CACHE_TAG_BYPASS_EN.
module tb_l2_cache_tag_array;

    localparam int NW = 4;
    localparam int NS = 256;
    localparam int TW = 18;
    localparam int WW = 2;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          arb_valid;
    logic [SW-1:0] arb_set;
    logic          arb_is_fill;
    logic          arb_ready;
    logic          tag_valid;
    logic [SW-1:0] tag_set;
    logic          tag_is_fill;
    logic [WW-1:0] tag_fill_way;
    logic [NW*TW-1:0] tag_l2_tag;
    logic [NW-1:0] tag_l2_valid;
    logic [NW-1:0] tag_l2_dirty;
    logic          upd_tag_en;
    logic [SW-1:0] upd_tag_set;
    logic [WW-1:0] upd_tag_way;
    logic [TW-1:0] upd_tag_tag;
    logic          upd_tag_valid;
    logic [NW-1:0] upd_dirty_en;
    logic [SW-1:0] upd_dirty_set;
    logic          upd_dirty_val;
    logic [WW-1:0] hit_way;
    logic          init_done;

    always #5 clk = ~clk;

    l2_cache_tag_array #(
        .NUM_WAYS  (NW),
        .NUM_SETS  (NS),
        .TAG_WIDTH (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arb_valid     (arb_valid),
        .arb_set       (arb_set),
        .arb_is_fill   (arb_is_fill),
        .arb_ready     (arb_ready),
        .tag_valid     (tag_valid),
        .tag_set       (tag_set),
        .tag_is_fill   (tag_is_fill),
        .tag_fill_way  (tag_fill_way),
        .tag_l2_tag    (tag_l2_tag),
        .tag_l2_valid  (tag_l2_valid),
        .tag_l2_dirty  (tag_l2_dirty),
        .upd_tag_en    (upd_tag_en),
        .upd_tag_set   (upd_tag_set),
        .upd_tag_way   (upd_tag_way),
        .upd_tag_tag   (upd_tag_tag),
        .upd_tag_valid (upd_tag_valid),
        .upd_dirty_en  (upd_dirty_en),
        .upd_dirty_set (upd_dirty_set),
        .upd_dirty_val (upd_dirty_val),
        .hit_way       (hit_way),
        .init_done     (init_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference state; PLRU tree uses 1-based heap nodes 1..NW-1.
    bit [TW-1:0] m_tag  [NS][NW];
    bit          m_val  [NS][NW];
    bit          m_dty  [NS][NW];
    bit          m_plru [NS][NW];

    bit p_valid;
    bit p_fill;
    int p_set;
    int p_way;

    function automatic void m_clear();
        foreach (m_val[s, w]) begin
            m_val[s][w]  = 1'b0;
            m_dty[s][w]  = 1'b0;
            m_plru[s][w] = 1'b0;
        end
        p_valid = 1'b0;
    endfunction

    function automatic int m_victim(int s);
        int lo   = 0;
        int span = NW;
        int node = 1;
        while (span > 1) begin
            span = span / 2;
            if (m_plru[s][node]) begin
                lo   = lo + span;
                node = node * 2 + 1;
            end else begin
                node = node * 2;
            end
        end
        return lo;
    endfunction

    function automatic void m_touch(int s, int way);
        int lo   = 0;
        int span = NW;
        int node = 1;
        while (span > 1) begin
            span = span / 2;
            if (way >= lo + span) begin
                m_plru[s][node] = 1'b0;
                lo   = lo + span;
                node = node * 2 + 1;
            end else begin
                m_plru[s][node] = 1'b1;
                node = node * 2;
            end
        end
    endfunction

    function automatic void m_write();
        if (upd_tag_en) begin
            m_tag[upd_tag_set][upd_tag_way] = upd_tag_tag;
            m_val[upd_tag_set][upd_tag_way] = upd_tag_valid;
        end
        for (int w = 0; w < NW; w++) begin
            if (upd_dirty_en[w]) m_dty[upd_dirty_set][w] = upd_dirty_val;
        end
    endfunction

    task automatic idle();
        arb_valid     = 1'b0;
        arb_set       = '0;
        arb_is_fill   = 1'b0;
        upd_tag_en    = 1'b0;
        upd_tag_set   = '0;
        upd_tag_way   = '0;
        upd_tag_tag   = '0;
        upd_tag_valid = 1'b0;
        upd_dirty_en  = '0;
        upd_dirty_set = '0;
        upd_dirty_val = 1'b0;
        hit_way       = '0;
    endtask

    // One clock: model the cycle, let the DUT take the edge, compare outputs.
    task automatic tick();
        int          vic = 0;
        bit          fire;
        bit [TW-1:0] rt [NW];
        bit          rv [NW];
        bit          rd [NW];
        if (p_valid) m_touch(p_set, p_fill ? p_way : int'(hit_way));
        fire = arb_valid;
        if (fire) vic = m_victim(int'(arb_set));
`ifdef L2_CACHE_TAG_BYPASS_EN
        m_write();
`endif
        for (int w = 0; w < NW; w++) begin
            rt[w] = m_tag[arb_set][w];
            rv[w] = m_val[arb_set][w];
            rd[w] = m_dty[arb_set][w];
        end
`ifndef L2_CACHE_TAG_BYPASS_EN
        m_write();
`endif
        @(posedge clk);
        #1;
        check("tag_valid", tag_valid, fire);
        if (fire) begin
            check("tag_set", tag_set, arb_set);
            check("tag_is_fill", tag_is_fill, arb_is_fill);
            check("fill_way", tag_fill_way, vic);
            for (int w = 0; w < NW; w++) begin
                check("l2_valid", tag_l2_valid[w], rv[w]);
                check("l2_dirty", tag_l2_dirty[w], rd[w]);
                if (rv[w]) check("l2_tag", tag_l2_tag[w*TW +: TW], rt[w]);
            end
        end else begin
            check("l2_valid_idle", tag_l2_valid, 0);
            check("l2_dirty_idle", tag_l2_dirty, 0);
        end
        p_valid = fire;
        p_set   = int'(arb_set);
        p_fill  = arb_is_fill;
        p_way   = vic;
        @(negedge clk);
    endtask

    task automatic read(int s);
        idle();
        arb_valid = 1'b1;
        arb_set   = SW'(s);
        tick();
    endtask

    task automatic do_reset();
        int n = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tag_valid", tag_valid, 0);
        check("rst_tag_is_fill", tag_is_fill, 0);
        check("rst_fill_way", tag_fill_way, 0);
        check("rst_tag_set", tag_set, 0);
        check("rst_arb_ready", arb_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_l2_valid", tag_l2_valid, 0);
        check("rst_l2_dirty", tag_l2_dirty, 0);
        @(negedge clk);
        reset = 1'b0;
        m_clear();
        while (!arb_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sweep_len", n, NS);
        check("init_done", init_done, 1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seq [5] = '{0, 2, 1, 3, 0};
        reset = 1'b1;
        idle();
        @(negedge clk);
        do_reset();

        read(0);
        check("set0_valid", tag_l2_valid, 0);

        for (int i = 0; i < 5; i++) begin
            idle();
            arb_valid   = 1'b1;
            arb_set     = 8'd5;
            arb_is_fill = 1'b1;
            tick();
            check("fill_seq", tag_fill_way, seq[i]);
        end
        idle();
        tick();

        idle();
        upd_tag_en    = 1'b1;
        upd_tag_set   = 8'd9;
        upd_tag_way   = 2'd2;
        upd_tag_tag   = 18'h1234;
        upd_tag_valid = 1'b1;
        tick();
        read(9);
        check("set9_valid", tag_l2_valid, 4'b0100);
        check("set9_tag", tag_l2_tag[2*TW +: TW], 18'h1234);

        idle();
        arb_valid     = 1'b1;
        arb_set       = 8'd9;
        upd_tag_en    = 1'b1;
        upd_tag_way   = 2'd1;
        upd_tag_tag   = 18'h0abc;
        upd_tag_valid = 1'b1;
`ifdef L2_CACHE_TAG_BYPASS_EN
        upd_tag_set = 8'd9;
        tick();
        check("bypass_valid", tag_l2_valid, 4'b0110);
        check("bypass_tag", tag_l2_tag[1*TW +: TW], 18'h0abc);
`else
        upd_tag_set = 8'd10;
        tick();
        check("other_set_wr", tag_l2_valid, 4'b0100);
`endif

        idle();
        upd_dirty_en  = 4'b1000;
        upd_dirty_set = 8'd3;
        upd_dirty_val = 1'b1;
        tick();
        read(3);
        check("dirty_set", tag_l2_dirty, 4'b1000);
        idle();
        upd_dirty_en  = 4'b1000;
        upd_dirty_set = 8'd3;
        upd_dirty_val = 1'b0;
        tick();
        read(3);
        check("dirty_clr", tag_l2_dirty, 4'b0000);

        for (int i = 0; i < 400; i++) begin
            arb_valid     = 1'($urandom_range(0, 1));
            arb_set       = SW'($urandom_range(0, 7));
            arb_is_fill   = 1'($urandom_range(0, 1));
            hit_way       = WW'($urandom_range(0, NW - 1));
            upd_tag_en    = ($urandom_range(0, 2) == 0);
            upd_tag_set   = SW'($urandom_range(0, 7));
            upd_tag_way   = WW'($urandom_range(0, NW - 1));
            upd_tag_tag   = TW'($urandom);
            upd_tag_valid = 1'($urandom_range(0, 3) != 0);
            upd_dirty_en  = ($urandom_range(0, 1) == 1) ? NW'($urandom_range(0, 15)) : '0;
            upd_dirty_set = SW'($urandom_range(0, 7));
            upd_dirty_val = 1'($urandom_range(0, 1));
`ifndef L2_CACHE_TAG_BYPASS_EN
            if (arb_valid) begin
                if (upd_tag_set == arb_set)   upd_tag_set   = arb_set ^ 8'd1;
                if (upd_dirty_set == arb_set) upd_dirty_set = arb_set ^ 8'd1;
            end
`endif
            tick();
        end
        idle();
        tick();

        idle();
        upd_tag_en    = 1'b1;
        upd_tag_set   = 8'd7;
        upd_tag_way   = 2'd0;
        upd_tag_tag   = 18'h00077;
        upd_tag_valid = 1'b1;
        tick();
        read(7);
        check("set7_written", tag_l2_valid[0], 1);

        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_sweep_ready", arb_ready, 0);
        do_reset();
        read(7);
        check("set7_cleared", tag_l2_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
